if_fetch_buf: RTL and testbench

Parametrised fetch-stage buffer between IF0 (PC generation) and IF1 (I-cache response/align); successor to the single-entry IF0→IF1 stage register. Holds up to DEPTH in-flight fetch entries {pc, pc_next} in a circular FIFO with valid/ready handshakes on both sides. IF0 can keep issuing while IF1 stalls. Supports a synchronous flush on redirect and an optional zero-latency bypass.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_fetch_buf_mem.sv | 31 +++
 rtl/if_fetch_buf.sv | 114 +++++++++++
 tb/tb_if_fetch_buf.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: reset PC, fetch entry layout, default buffer depth.
package if_pkg;

  localparam int unsigned IF_PC_W      = 32;
  localparam int unsigned IF_BUF_DEPTH = 2;

  localparam logic [IF_PC_W-1:0] PC_RESET = 32'h1c000000;

  // One in-flight fetch: the PC being fetched and the predicted next PC.
  typedef struct packed {
    logic [IF_PC_W-1:0] pc;
    logic [IF_PC_W-1:0] pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf_mem.sv
// Entry storage for the fetch buffer: DEPTH x W register array,
// one synchronous write port and one asynchronous read port, no reset.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - write data
//   i_raddr  - read index
//   o_rdata  - read data (combinational from the array)
module if_fetch_buf_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Contents are intentionally left unreset; pointers gate visibility.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_buf.sv
// IF0 -> IF1 fetch buffer: circular FIFO of {pc, pc_next} entries with
// valid/ready on both sides and synchronous flush on redirect.
// Optional feature macro: IF_FETCH_BUF_BYPASS_EN (zero-latency path when empty).
// Ports:
//   clk, rst                 - clock, async active-high reset
//   in_valid/in_ready        - IF0 handshake; in_ready = !full && rready
//   rready                   - I-cache can take a request
//   in_pc/in_pc_next         - offered entry
//   out_valid/out_ready      - IF1 handshake
//   out_pc/out_pc_next       - head entry (PC_RESET / PC_RESET+8 when empty)
//   flush                    - discard all entries
//   count                    - occupied entries
module if_fetch_buf #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       DEPTH    = if_pkg::IF_BUF_DEPTH,
  parameter logic [PC_W-1:0]   PC_RESET = PC_W'(if_pkg::PC_RESET)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [PC_W-1:0]          in_pc_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [PC_W-1:0]          out_pc_next,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 * PC_W;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_byp;
  logic          w_byp_take;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Zero-latency path: only when nothing is queued ahead of the input.
`ifdef IF_FETCH_BUF_BYPASS_EN
  assign w_byp = w_empty && in_valid && rready && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed entry consumed the same cycle is never written.
  assign w_byp_take = w_byp && out_ready;

  // Full blocks the push even when a pop happens in the same cycle.
  assign in_ready  = !w_full && rready;
  assign w_push    = in_valid && in_ready && !flush && !w_byp_take;
  assign w_pop     = !flush && !w_empty && out_ready;
  assign out_valid = !flush && (!w_empty || w_byp);

  always_comb begin
    out_pc      = w_rdata[EW-1:PC_W];
    out_pc_next = w_rdata[PC_W-1:0];
    if (w_empty) begin
      if (w_byp) begin
        out_pc      = in_pc;
        out_pc_next = in_pc_next;
      end else begin
        out_pc      = PC_RESET;
        out_pc_next = PC_RESET + PC_W'(8);
      end
    end
  end

  assign count = r_count;

  // Pointer and occupancy tracking; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  if_fetch_buf_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_pc, in_pc_next}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf (DEPTH=2) with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_if_fetch_buf;
  import if_pkg::*;

  localparam int unsigned DEPTH = 2;
`ifdef IF_FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, rready;
  logic [31:0] in_pc, in_pc_next;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_pc_next;
  logic        flush;
  logic [1:0]  count;

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;
  bit seen_flushed = 1'b0;

  fetch_entry_t model_q[$];

  if_fetch_buf #(.PC_W(32), .DEPTH(DEPTH), .PC_RESET(32'h1c000000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rready(rready), .in_pc(in_pc), .in_pc_next(in_pc_next),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare at negedge, then advance to the state after the next edge.
  always @(negedge clk) begin
    if (!done) begin
      bit          e_valid;
      logic [31:0] e_pc, e_pcn;
      bit          take, push, pop;
      int          sz;
      sz = model_q.size();
      if (rst) begin
        model_q.delete();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_pc", out_pc, 32'h1c000000);
        chk("rst_in_ready", 32'(in_ready), 32'(rready));
      end else begin
        e_valid = 1'b0;
        e_pc    = 32'h1c000000;
        e_pcn   = 32'h1c000008;
        take    = 1'b0;
        if (sz > 0) begin
          e_valid = !flush;
          e_pc    = model_q[0].pc;
          e_pcn   = model_q[0].pc_next;
        end else if (BYP && in_valid && rready && !flush) begin
          e_valid = 1'b1;
          e_pc    = in_pc;
          e_pcn   = in_pc_next;
          take    = out_ready;
        end
        chk("m_out_valid", 32'(out_valid), 32'(e_valid));
        chk("m_in_ready", 32'(in_ready), 32'((sz < DEPTH) && rready));
        chk("m_count", 32'(count), 32'(sz));
        if (!flush || sz == 0) begin
          chk("m_out_pc", out_pc, e_pc);
          chk("m_out_pc_next", out_pc_next, e_pcn);
        end
        if (out_valid && out_pc == 32'h1c000100) seen_flushed = 1'b1;
        if (flush) model_q.delete();
        else begin
          pop  = (sz > 0) && out_ready;
          push = in_valid && rready && (sz < DEPTH) && !take;
          if (pop) void'(model_q.pop_front());
          if (push) model_q.push_back('{pc: in_pc, pc_next: in_pc_next});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic peek;
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_pc_next = pc + 32'd8;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; rready = 1'b1; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_pc_next = '0;
    peek;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_pc", out_pc, 32'h1c000000);
    chk("reset_out_pc_next", out_pc_next, 32'h1c000008);
    chk("reset_count", 32'(count), 32'd0);
    tick;
    rst = 1'b0;
    peek;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Fill with IF1 stalled
    tick;
    offer(32'h1c000000); tick;
    offer(32'h1c000008); tick;
    offer(32'h1c000010);
    peek;
    chk("fill_count", 32'(count), 32'd2);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    tick;
    in_valid = 1'b0; out_ready = 1'b1;
    peek;
    chk("pop0_pc", out_pc, 32'h1c000000);
    tick; peek;
    chk("pop1_pc", out_pc, 32'h1c000008);
    tick; peek;
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Streaming
    tick;
    for (int i = 0; i < 10; i++) begin
      offer(32'h1c000200 + 32'(8 * i));
      peek;
      if (i > 0) begin
        if (BYP) begin
          chk("stream_count", 32'(count), 32'd0);
          chk("stream_pc", out_pc, 32'h1c000200 + 32'(8 * i));
        end else begin
          chk("stream_count", 32'(count), 32'd1);
          chk("stream_pc", out_pc, 32'h1c000200 + 32'(8 * (i - 1)));
        end
      end
      tick;
    end
    in_valid = 1'b0;
    tick; tick;

    // Full with simultaneous pop
    out_ready = 1'b0;
    offer(32'h1c000400); tick;
    offer(32'h1c000408); tick;
    offer(32'h1c000410); out_ready = 1'b1;
    peek;
    chk("fullpop_in_ready", 32'(in_ready), 32'd0);
    chk("fullpop_count", 32'(count), 32'd2);
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    peek;
    chk("fullpop_count_after", 32'(count), 32'd1);
    chk("fullpop_head", out_pc, 32'h1c000408);
    tick;
    out_ready = 1'b1; tick; tick;

    // Flush with entries queued and an offer in flight
    out_ready = 1'b0;
    offer(32'h1c000500); tick;
    offer(32'h1c000508); tick;
    offer(32'h1c000100); flush = 1'b1;
    peek;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    peek;
    chk("flush_count", 32'(count), 32'd0);
    tick; tick; tick;
    chk("flushed_entry_seen", 32'(seen_flushed), 32'd0);

    // rready low blocks acceptance
    rready = 1'b0;
    offer(32'h1c000600);
    peek;
    chk("rready_in_ready", 32'(in_ready), 32'd0);
    chk("rready_out_valid", 32'(out_valid), 32'd0);
    tick; peek;
    chk("rready_count", 32'(count), 32'd0);
    tick;

    // Empty buffer, all conditions for the zero-latency path
    rready = 1'b1;
    offer(32'h1c000300);
    peek;
    if (BYP) chk("byp_out_pc", out_pc, 32'h1c000300);
    else     chk("byp_out_valid", 32'(out_valid), 32'd0);
    tick;
    in_valid = 1'b0;
    peek;
    chk("byp_count", 32'(count), BYP ? 32'd0 : 32'd1);
    tick; tick;

    // Reset mid-stream drops entries; first edge after release accepts
    out_ready = 1'b0;
    offer(32'h1c000700); tick;
    rst = 1'b1;
    peek;
    chk("midrst_count", 32'(count), 32'd0);
    tick;
    rst = 1'b0;
    offer(32'h1c000708);
    tick;
    in_valid = 1'b0;
    peek;
    chk("postrst_count", 32'(count), 32'd1);
    chk("postrst_pc", out_pc, 32'h1c000708);
    tick;

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
